// File: rtl/vga_pkg.sv
// Shared timing defaults, sprite palette and sprite state types for the VGA sprite engine.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;   // 1 = moving towards larger coordinates
  } axis_t;

  typedef struct packed {
    axis_t hx;
    axis_t vy;
  } sprite_t;

  function automatic logic [11:0] sprite_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hFF0;
      3'd1:    c = 12'hF00;
      3'd2:    c = 12'h0F0;
      3'd3:    c = 12'h0FF;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hFFF;
      3'd6:    c = 12'hF80;
      default: c = 12'h00F;
    endcase
    return c;
  endfunction

  // 11-bit arithmetic so pos+step never wraps before the limit compare.
  function automatic axis_t axis_step(input axis_t a, input logic [10:0] limit,
                                      input logic [10:0] step);
    axis_t       r;
    logic [10:0] p;
    logic [10:0] n;
    r = a;
    p = {1'b0, a.pos};
    if (a.dir) begin
      n = p + step;
      if (n > limit) begin
        r.pos = limit[9:0];
        r.dir = 1'b0;
      end else begin
        r.pos = n[9:0];
      end
    end else begin
      n = p - step;
      if (p < step) begin
        r.pos = '0;
        r.dir = 1'b1;
      end else begin
        r.pos = n[9:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider plus horizontal/vertical counters with raw sync and active flags.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_tick,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        hsync_act,
  output logic        vsync_act,
  output logic        active,
  output logic        first_px,
  output logic        frame_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [10:0]   H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0]   V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0]   H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]   V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0]   HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [10:0]   h_q, h_d;
  logic [10:0]   v_q, v_d;

  assign pix_tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = pix_tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (pix_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign h_cnt      = h_q;
  assign v_cnt      = v_q;
  assign hsync_act  = (h_q >= HS_START) && (h_q < HS_END);
  assign vsync_act  = (v_q >= VS_START) && (v_q < VS_END);
  assign active     = (h_q < H_ACT) && (v_q < V_ACT);
  assign first_px   = (h_q == '0) && (v_q == '0);
  assign frame_last = pix_tick && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_sprite_engine.sv
// VGA timing plus bouncing solid-square sprites; sync, colour and flags leave through one
// shared output register so they stay aligned at the connector.
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int SYNC_POL    = 0,
  parameter int NUM_SPRITES = 3,
  parameter int SIZE        = 32,
  parameter int STEP        = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_en,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       in_display,
  output logic       frame_start
);

  localparam logic        SYNC_ACT = (SYNC_POL != 0);
  localparam logic [10:0] SZ       = 11'(SIZE);
  localparam logic [10:0] STP      = 11'(STEP);
  localparam logic [10:0] X_LIM    = 11'(H_ACTIVE - SIZE);
  localparam logic [10:0] Y_LIM    = 11'(V_ACTIVE - SIZE);

  logic        pix_tick;
  logic [10:0] h_cnt, v_cnt;
  logic        hsync_act, vsync_act, active, first_px, frame_last;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_tick  (pix_tick),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .hsync_act (hsync_act),
    .vsync_act (vsync_act),
    .active    (active),
    .first_px  (first_px),
    .frame_last(frame_last)
  );

  function automatic sprite_t sprite_init(input int idx);
    sprite_t s;
    s.hx.pos = 10'(idx * 2 * SIZE);
    s.hx.dir = 1'b1;
    s.vy.pos = 10'(idx * SIZE);
    s.vy.dir = ~idx[0];
    return s;
  endfunction

  sprite_t spr_q [NUM_SPRITES];
  sprite_t spr_d [NUM_SPRITES];

  // Positions only change on the last tick of a frame, so every frame is drawn from one snapshot.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      spr_d[i] = spr_q[i];
      if (frame_last && move_en) begin
        spr_d[i].hx = axis_step(spr_q[i].hx, X_LIM, STP);
        spr_d[i].vy = axis_step(spr_q[i].vy, Y_LIM, STP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) spr_q[i] <= sprite_init(i);
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) spr_q[i] <= spr_d[i];
    end
  end

  logic [11:0] pix_rgb;
  logic [10:0] sx, sy;

  // Scanning from the highest index down lets the lowest hit index overwrite the others.
  always_comb begin
    pix_rgb = '0;
    sx      = '0;
    sy      = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      sx = {1'b0, spr_q[i].hx.pos};
      sy = {1'b0, spr_q[i].vy.pos};
      if ((h_cnt >= sx) && (h_cnt < sx + SZ) && (v_cnt >= sy) && (v_cnt < sy + SZ)) begin
        pix_rgb = sprite_colour(3'(i));
      end
    end
    if (!active) pix_rgb = '0;
  end

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [11:0] rgb_q, rgb_d;
  logic        de_q, de_d;
  logic        fs_q, fs_d;

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    de_d    = de_q;
    fs_d    = 1'b0;
    if (pix_tick) begin
      hsync_d = hsync_act ? SYNC_ACT : ~SYNC_ACT;
      vsync_d = vsync_act ? SYNC_ACT : ~SYNC_ACT;
      rgb_d   = pix_rgb;
      de_d    = active;
      fs_d    = first_px;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= ~SYNC_ACT;
      vsync_q <= ~SYNC_ACT;
      rgb_q   <= '0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign in_display  = de_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Self-checking bench: small raster, random per-frame move_en, every clock compared to a frame-level model.
module tb_vga_sprite_engine;

  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 32;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 20;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int NUM      = 3;
  localparam int SIZE     = 4;
  localparam int STEP     = 3;
  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = HT * VT;

  logic       clk;
  logic       rst_n;
  logic       move_en;
  logic       hsync_out, vsync_out, in_display, frame_start;
  logic [3:0] vga_r, vga_g, vga_b;

  vga_sprite_engine #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(0), .NUM_SPRITES(NUM), .SIZE(SIZE), .STEP(STEP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .move_en    (move_en),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .in_display (in_display),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int overlap_px = 0;
  int bounces = 0;

  logic [11:0] pal [8] = '{12'hFF0, 12'hF00, 12'h0F0, 12'h0FF, 12'hF0F, 12'hFFF, 12'hF80, 12'h00F};

  // Reference sprite state, one entry per frame rather than per clock.
  int mx [NUM];
  int my [NUM];
  bit mdx [NUM];
  bit mdy [NUM];
  int  model_frame;
  bit  frame_move;
  int  edge_cnt;
  bit  first_phase;

  localparam logic [15:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 12'h000};

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got hs/vs/de/fs/rgb=%h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] observed();
    return {hsync_out, vsync_out, in_display, frame_start, vga_r, vga_g, vga_b};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      mx[i]  = i * 2 * SIZE;
      my[i]  = i * SIZE;
      mdx[i] = 1'b1;
      mdy[i] = (i % 2 == 0);
    end
    model_frame = 0;
    edge_cnt    = 0;
  endtask

  task automatic step_axis(inout int p, inout bit d, input int lim);
    if (d) begin
      if (p + STEP > lim) begin p = lim; d = 1'b0; bounces++; end
      else p = p + STEP;
    end else begin
      if (p < STEP) begin p = 0; d = 1'b1; bounces++; end
      else p = p - STEP;
    end
  endtask

  function automatic logic [15:0] expected_px(input int h, input int v, input bit tick);
    logic [11:0] rgb;
    bit hs_a, vs_a, de;
    int hits;
    rgb  = 12'h000;
    hits = 0;
    hs_a = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
    vs_a = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
    de   = (h < H_ACTIVE) && (v < V_ACTIVE);
    if (de) begin
      for (int i = 0; i < NUM; i++) begin
        if (h >= mx[i] && h < mx[i] + SIZE && v >= my[i] && v < my[i] + SIZE) begin
          if (hits == 0) rgb = pal[i];
          hits++;
        end
      end
    end
    if (hits > 1 && tick) overlap_px++;
    return {~hs_a, ~vs_a, de, tick && h == 0 && v == 0, rgb};
  endfunction

  task automatic sample();
    int p, h, v, fr;
    bit tick;
    if (edge_cnt < CLK_DIV) begin
      check_vec("pre_tick", observed(), RESET_VEC);
      return;
    end
    p    = edge_cnt / CLK_DIV - 1;
    tick = (edge_cnt % CLK_DIV) == 0;
    fr   = p / FRAME;
    h    = (p % FRAME) % HT;
    v    = (p % FRAME) / HT;
    while (model_frame < fr) begin
      if (frame_move) begin
        for (int i = 0; i < NUM; i++) begin
          step_axis(mx[i], mdx[i], H_ACTIVE - SIZE);
          step_axis(my[i], mdy[i], V_ACTIVE - SIZE);
        end
      end
      model_frame++;
    end
    check_vec($sformatf("px f%0d h%0d v%0d", fr, h, v), observed(), expected_px(h, v, tick));
    if (tick && h == 0 && v == 0) begin
      move_en    = (first_phase && fr < 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
      frame_move = move_en;
    end
  endtask

  task automatic run_edges(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      edge_cnt++;
      sample();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    move_en     = 1'b0;
    frame_move  = 1'b0;
    first_phase = 1'b1;
    model_reset();
    repeat (10) @(posedge clk);
    #1;
    check_vec("reset_state", observed(), RESET_VEC);
    @(negedge clk);
    rst_n = 1'b1;
    edge_cnt = 0;

    run_edges(18 * FRAME * CLK_DIV + 37 * CLK_DIV + 1);

    // Asynchronous reset in the middle of a line, away from the clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("async_reset_now", observed(), RESET_VEC);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_vec($sformatf("reset_hold%0d", k), observed(), RESET_VEC);
    end
    @(negedge clk);
    first_phase = 1'b1;
    move_en     = 1'b0;
    frame_move  = 1'b0;
    model_reset();
    rst_n = 1'b1;

    run_edges(11 * FRAME * CLK_DIV + 10);

    $display("info: overlap pixels %0d, bounces %0d", overlap_px, bounces);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
